// File: rtl/sram_like_stall_ctrl.sv
// Per-channel CPU-to-sram-like bridge with a shared pipeline stall.
// Latency: 2 cycles minimum (IDLE stall cycle, then REQ with addr_ok and data_ok in the same cycle).
// Backpressure: holds bus_req until addr_ok; a channel that finishes early parks in HOLD until every channel is done.
module sram_like_stall_ctrl #(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         cpu_en,
  input  logic [NCH*(DATA_W/8)-1:0] cpu_wen,
  input  logic [NCH*ADDR_W-1:0]  cpu_addr,
  input  logic [NCH*DATA_W-1:0]  cpu_wdata,
  input  logic [NCH*2-1:0]       cpu_size,
  output logic [NCH*DATA_W-1:0]  cpu_rdata,
  output logic [NCH-1:0]         cpu_stall,
  output logic                   longest_stall,
  output logic [NCH-1:0]         bus_req,
  output logic [NCH-1:0]         bus_wr,
  output logic [NCH*2-1:0]       bus_size,
  output logic [NCH*ADDR_W-1:0]  bus_addr,
  output logic [NCH*DATA_W-1:0]  bus_wdata,
  input  logic [NCH-1:0]         bus_addr_ok,
  input  logic [NCH-1:0]         bus_data_ok,
  input  logic [NCH*DATA_W-1:0]  bus_rdata
);

  localparam int WB = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  logic [NCH-1:0] done;

  // The pipeline only advances once every active channel has its result.
  assign longest_stall = |cpu_stall;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t              state;
    state_t              state_nxt;
    logic                complete;
    logic                wr_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rbuf_q;
    logic                en;

    assign en = cpu_en[i];

    // Data_ok only finishes a transfer once the slave has the address; IDLE/HOLD ignore it.
    assign complete = ((state == S_WAIT) && bus_data_ok[i]) ||
                      ((state == S_REQ) && bus_addr_ok[i] && bus_data_ok[i]);

    assign done[i]      = complete || (state == S_HOLD);
    assign cpu_stall[i] = en && !done[i];

    // Next-state: issue, wait for accept, wait for data, then park until the whole pipeline is free.
    always_comb begin
      state_nxt = state;
      case (state)
        S_IDLE: if (en) state_nxt = S_REQ;
        S_REQ:  if (bus_addr_ok[i] && !bus_data_ok[i]) state_nxt = S_WAIT;
        S_WAIT: state_nxt = S_WAIT;
        S_HOLD: if (!longest_stall) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
      // A dropped cpu_en means nobody wants the result, so there is nothing to hold.
      if (complete) state_nxt = (en && longest_stall) ? S_HOLD : S_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
    end

    // Request fields latch on issue and stay frozen until the transfer ends; read data buffers on completion.
    always_ff @(posedge clk) begin
      if (!rst) begin
        wr_q    <= 1'b0;
        size_q  <= 2'd0;
        addr_q  <= '0;
        wdata_q <= '0;
        rbuf_q  <= '0;
      end else begin
        if ((state == S_IDLE) && en) begin
          wr_q    <= |cpu_wen[i*WB +: WB];
          size_q  <= cpu_size[i*2 +: 2];
          addr_q  <= cpu_addr[i*ADDR_W +: ADDR_W];
          wdata_q <= cpu_wdata[i*DATA_W +: DATA_W];
        end
        if (complete && en) rbuf_q <= bus_rdata[i*DATA_W +: DATA_W];
      end
    end

    // Bus outputs are forced quiet while reset is held, even before the first edge.
    assign bus_req[i]                   = rst && (state == S_REQ);
    assign bus_wr[i]                    = rst && wr_q;
    assign bus_size[i*2 +: 2]           = rst ? size_q : 2'd0;
    assign bus_addr[i*ADDR_W +: ADDR_W] = rst ? addr_q : '0;
    assign bus_wdata[i*DATA_W +: DATA_W] = rst ? wdata_q : '0;

    // Forward the bus data in the completion cycle so the pipeline need not wait a cycle.
    assign cpu_rdata[i*DATA_W +: DATA_W] = complete ? bus_rdata[i*DATA_W +: DATA_W] : rbuf_q;
  end

endmodule

// File: tb/tb_sram_like_stall_ctrl.sv
module tb_sram_like_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-channel, 32-bit instance
  logic [1:0]  cpu_en;
  logic [7:0]  cpu_wen;
  logic [63:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_size;
  logic [63:0] cpu_rdata;
  logic [1:0]  cpu_stall;
  logic        longest_stall;
  logic [1:0]  bus_req, bus_wr;
  logic [3:0]  bus_size;
  logic [63:0] bus_addr, bus_wdata;
  logic [1:0]  bus_addr_ok, bus_data_ok;
  logic [63:0] bus_rdata;

  // 3-channel, 64-bit instance
  logic [2:0]   b_cpu_en;
  logic [23:0]  b_cpu_wen;
  logic [95:0]  b_cpu_addr;
  logic [191:0] b_cpu_wdata;
  logic [5:0]   b_cpu_size;
  logic [191:0] b_cpu_rdata;
  logic [2:0]   b_cpu_stall;
  logic         b_longest_stall;
  logic [2:0]   b_bus_req, b_bus_wr;
  logic [5:0]   b_bus_size;
  logic [95:0]  b_bus_addr;
  logic [191:0] b_bus_wdata;
  logic [2:0]   b_bus_addr_ok, b_bus_data_ok;
  logic [191:0] b_bus_rdata;

  int checks = 0;
  int errors = 0;
  int req0_seen;

  sram_like_stall_ctrl #(.NCH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_size(cpu_size), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .longest_stall(longest_stall), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  sram_like_stall_ctrl #(.NCH(3), .ADDR_W(32), .DATA_W(64)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_en(b_cpu_en), .cpu_wen(b_cpu_wen), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_size(b_cpu_size), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .longest_stall(b_longest_stall), .bus_req(b_bus_req), .bus_wr(b_bus_wr),
    .bus_size(b_bus_size), .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata),
    .bus_addr_ok(b_bus_addr_ok), .bus_data_ok(b_bus_data_ok), .bus_rdata(b_bus_rdata)
  );

  // Advance one cycle; inputs are then driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, then compare.
  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    cpu_en = '0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0; cpu_size = '0;
    bus_addr_ok = '0; bus_data_ok = '0; bus_rdata = '0;
    b_cpu_en = '0; b_cpu_wen = '0; b_cpu_addr = '0; b_cpu_wdata = '0; b_cpu_size = '0;
    b_bus_addr_ok = '0; b_bus_data_ok = '0; b_bus_rdata = '0;

    // ---- reset state ----
    step(); step();
    cpu_en = 2'b11; settle();
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_b_rdata", b_cpu_rdata[63:0], 0);
    cpu_en = 2'b00;
    step();
    rst = 1'b1; settle();
    chk("idle_stall", cpu_stall, 0);
    chk("idle_longest", longest_stall, 0);

    // ---- zero-wait read on ch0, then back-to-back second read ----
    step();
    cpu_en = 2'b01; cpu_addr[31:0] = 32'hBFC0_0000; cpu_size[1:0] = 2'd2; settle();
    chk("rd_c0_stall", cpu_stall, 2'b01);
    chk("rd_c0_longest", longest_stall, 1);
    chk("rd_c0_req", bus_req, 0);
    step();
    bus_addr_ok = 2'b01; bus_data_ok = 2'b01; bus_rdata[31:0] = 32'h3C1D_0000; settle();
    chk("rd_c1_req", bus_req, 2'b01);
    chk("rd_c1_addr", bus_addr[31:0], 32'hBFC0_0000);
    chk("rd_c1_wr", bus_wr[0], 0);
    chk("rd_c1_size", bus_size[1:0], 2);
    chk("rd_c1_stall", cpu_stall, 0);
    chk("rd_c1_longest", longest_stall, 0);
    chk("rd_c1_rdata", cpu_rdata[31:0], 32'h3C1D_0000);
    step();
    cpu_addr[31:0] = 32'hBFC0_0004;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0; settle();
    chk("b2b_c2_req", bus_req, 0);
    chk("b2b_c2_stall", cpu_stall, 2'b01);
    chk("b2b_c2_buf", cpu_rdata[31:0], 32'h3C1D_0000);
    step();
    bus_addr_ok = 2'b01; bus_data_ok = 2'b01; bus_rdata[31:0] = 32'h27BD_FFF0; settle();
    chk("b2b_c3_req", bus_req, 2'b01);
    chk("b2b_c3_addr", bus_addr[31:0], 32'hBFC0_0004);
    chk("b2b_c3_rdata", cpu_rdata[31:0], 32'h27BD_FFF0);
    step();
    cpu_en = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0; settle();
    chk("b2b_c4_buf", cpu_rdata[31:0], 32'h27BD_FFF0);
    chk("b2b_c4_stall", cpu_stall, 0);

    // ---- split completion: ch0 at cycle 2, ch1 at cycle 6 ----
    req0_seen = 0;
    step();
    cpu_en = 2'b11; cpu_addr = {32'h0000_2000, 32'h0000_1000}; cpu_size = 4'b1010; settle();
    chk("spl_c0_stall", cpu_stall, 2'b11);
    req0_seen += int'(bus_req[0]);
    step();
    bus_addr_ok = 2'b11; settle();
    chk("spl_c1_req", bus_req, 2'b11);
    chk("spl_c1_longest", longest_stall, 1);
    req0_seen += int'(bus_req[0]);
    step();
    bus_addr_ok = 0; bus_data_ok = 2'b01; bus_rdata = {32'h0, 32'hAAAA_0001}; settle();
    chk("spl_c2_stall", cpu_stall, 2'b10);
    chk("spl_c2_rdata0", cpu_rdata[31:0], 32'hAAAA_0001);
    chk("spl_c2_longest", longest_stall, 1);
    req0_seen += int'(bus_req[0]);
    for (int c = 3; c <= 5; c++) begin
      step();
      // stray data_ok on ch0 while it is parked must be ignored
      bus_data_ok = (c == 3) ? 2'b01 : 2'b00;
      bus_rdata = {32'h0, 32'hDEAD_BEEF}; settle();
      chk($sformatf("spl_c%0d_stall", c), cpu_stall, 2'b10);
      chk($sformatf("spl_c%0d_longest", c), longest_stall, 1);
      chk($sformatf("spl_c%0d_hold0", c), cpu_rdata[31:0], 32'hAAAA_0001);
      req0_seen += int'(bus_req[0]);
    end
    step();
    bus_data_ok = 2'b10; bus_rdata = {32'hBBBB_0002, 32'h0}; settle();
    chk("spl_c6_stall", cpu_stall, 0);
    chk("spl_c6_longest", longest_stall, 0);
    chk("spl_c6_rdata1", cpu_rdata[63:32], 32'hBBBB_0002);
    chk("spl_c6_hold0", cpu_rdata[31:0], 32'hAAAA_0001);
    req0_seen += int'(bus_req[0]);
    step();
    cpu_en = 0; bus_data_ok = 0; bus_rdata = '0; settle();
    chk("spl_c7_req", bus_req, 0);
    chk("spl_c7_stall", cpu_stall, 0);
    req0_seen += int'(bus_req[0]);
    step(); settle();
    chk("spl_c8_req", bus_req, 0);
    chk("spl_req0_count", req0_seen, 1);

    // ---- byte write on ch1 with 3 cycles of addr_ok=0 ----
    step();
    cpu_en = 2'b10; cpu_wen = 8'b0001_0000; cpu_size = 4'b0000;
    cpu_addr[63:32] = 32'h8000_0003; cpu_wdata[63:32] = 32'h0000_00AA; settle();
    chk("wr_c0_stall", cpu_stall, 2'b10);
    for (int c = 1; c <= 3; c++) begin
      step();
      cpu_wen = 0; cpu_size = 4'b1010; cpu_addr[63:32] = 32'h1234_5678; cpu_wdata[63:32] = 32'h5A5A_5A5A;
      settle();
      chk($sformatf("wr_c%0d_req", c), bus_req, 2'b10);
      chk($sformatf("wr_c%0d_wr", c), bus_wr[1], 1);
      chk($sformatf("wr_c%0d_size", c), bus_size[3:2], 0);
      chk($sformatf("wr_c%0d_addr", c), bus_addr[63:32], 32'h8000_0003);
      chk($sformatf("wr_c%0d_wdata", c), bus_wdata[63:32], 32'h0000_00AA);
      chk($sformatf("wr_c%0d_stall", c), cpu_stall, 2'b10);
    end
    step();
    bus_addr_ok = 2'b10; bus_data_ok = 2'b10; bus_rdata = {32'h5555_0005, 32'h0}; settle();
    chk("wr_c4_stall", cpu_stall, 0);
    chk("wr_c4_addr", bus_addr[63:32], 32'h8000_0003);
    step();
    cpu_en = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0; settle();
    chk("wr_c5_req", bus_req, 0);
    chk("wr_c5_buf", cpu_rdata[63:32], 32'h5555_0005);

    // ---- cpu_en drops on ch1 while in REQ ----
    step();
    cpu_en = 2'b10; cpu_addr[63:32] = 32'h0000_3000; settle();
    step();
    cpu_en = 0; settle();
    chk("drop_c1_req", bus_req, 2'b10);
    chk("drop_c1_stall", cpu_stall, 0);
    chk("drop_c1_addr", bus_addr[63:32], 32'h0000_3000);
    step();
    bus_addr_ok = 2'b10; settle();
    chk("drop_c2_req", bus_req, 2'b10);
    step();
    bus_addr_ok = 0; bus_data_ok = 2'b10; bus_rdata = {32'hCCCC_0003, 32'h0}; settle();
    chk("drop_c3_req", bus_req, 0);
    chk("drop_c3_stall", cpu_stall, 0);
    step();
    bus_data_ok = 0; bus_rdata = '0; settle();
    chk("drop_c4_req", bus_req, 0);
    chk("drop_c4_buf", cpu_rdata[63:32], 32'h5555_0005);
    cpu_en = 2'b10; settle();
    chk("drop_c4_idle", cpu_stall, 2'b10);
    cpu_en = 0;
    step(); settle();
    chk("drop_c5_req", bus_req, 0);

    // ---- reset in WAIT, stray data_ok afterwards ----
    step();
    cpu_en = 2'b01; cpu_addr[31:0] = 32'h0000_4000; settle();
    step();
    bus_addr_ok = 2'b01; settle();
    chk("rstm_c1_req", bus_req, 2'b01);
    step();
    bus_addr_ok = 0; rst = 1'b0; settle();
    chk("rstm_c2_req", bus_req, 0);
    chk("rstm_c2_addr", bus_addr, 0);
    step();
    rst = 1'b1; cpu_en = 0; bus_data_ok = 2'b01; bus_rdata = {32'h0, 32'h9999_9999}; settle();
    chk("rstm_c3_req", bus_req, 0);
    chk("rstm_c3_rdata", cpu_rdata, 0);
    chk("rstm_c3_stall", cpu_stall, 0);
    step();
    bus_data_ok = 0; bus_rdata = '0; settle();
    chk("rstm_c4_rdata", cpu_rdata, 0);
    chk("rstm_c4_req", bus_req, 0);

    // ---- 3 channels, 64-bit data, staggered completion ----
    step();
    b_cpu_en = 3'b111; b_cpu_size = 6'b101010;
    b_cpu_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100}; settle();
    chk("w3_c0_stall", b_cpu_stall, 3'b111);
    step();
    b_bus_addr_ok = 3'b111; settle();
    chk("w3_c1_req", b_bus_req, 3'b111);
    chk("w3_c1_addr2", b_bus_addr[95:64], 32'h0000_0300);
    step();
    b_bus_addr_ok = 0; b_bus_data_ok = 3'b001;
    b_bus_rdata = {64'h0, 64'h0, 64'h1111_0000_0000_0001}; settle();
    chk("w3_c2_stall", b_cpu_stall, 3'b110);
    chk("w3_c2_longest", b_longest_stall, 1);
    step();
    b_bus_data_ok = 3'b100;
    b_bus_rdata = {64'h3333_0000_0000_0003, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF}; settle();
    chk("w3_c3_stall", b_cpu_stall, 3'b010);
    chk("w3_c3_longest", b_longest_stall, 1);
    chk("w3_c3_rd0", b_cpu_rdata[63:0], 64'h1111_0000_0000_0001);
    step();
    b_bus_data_ok = 3'b010;
    b_bus_rdata = {64'hEEEE_EEEE_EEEE_EEEE, 64'h2222_0000_0000_0002, 64'h0}; settle();
    chk("w3_c4_stall", b_cpu_stall, 0);
    chk("w3_c4_longest", b_longest_stall, 0);
    chk("w3_c4_rd0", b_cpu_rdata[63:0], 64'h1111_0000_0000_0001);
    chk("w3_c4_rd1", b_cpu_rdata[127:64], 64'h2222_0000_0000_0002);
    chk("w3_c4_rd2", b_cpu_rdata[191:128], 64'h3333_0000_0000_0003);
    step();
    b_cpu_en = 0; b_bus_data_ok = 0; b_bus_rdata = '1; settle();
    chk("w3_c5_longest", b_longest_stall, 0);
    chk("w3_c5_req", b_bus_req, 0);
    chk("w3_c5_rd1", b_cpu_rdata[127:64], 64'h2222_0000_0000_0002);
    chk("w3_c5_rd2", b_cpu_rdata[191:128], 64'h3333_0000_0000_0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
